// File: rtl/uart_rx_cfg_if.sv
// Receiver-side bundle: line input, pacing tick, runtime parity mode,
// and the received word with its status flags.
interface uart_rx_cfg_if #(
  parameter int DBIT = 8
);
  logic            s_tick;
  logic            rx;
  logic            par_en;
  logic            par_odd;
  logic [DBIT-1:0] rx_dout;
  logic            rx_done_tick;
  logic            parity_err;
  logic            frame_err;
  logic            break_det;

  modport master (
    input  s_tick, rx, par_en, par_odd,
    output rx_dout, rx_done_tick, parity_err, frame_err, break_det
  );

  modport slave (
    output s_tick, rx, par_en, par_odd,
    input  rx_dout, rx_done_tick, parity_err, frame_err, break_det
  );
endinterface

// File: rtl/uart_rx_cfg.sv
// Oversampling UART receiver with runtime parity, glitch-filtered start bit,
// framing/break detection and a two-flop input synchroniser.
module uart_rx_cfg #(
  parameter int DBIT    = 8,
  parameter int OVS     = 16,
  parameter int SB_TICK = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  uart_rx_cfg_if.master  bus
);
  localparam int SMAX = (OVS > SB_TICK) ? OVS : SB_TICK;
  localparam int SW   = $clog2(SMAX);
  localparam int NW   = (DBIT > 1) ? $clog2(DBIT) : 1;

  localparam logic [SW-1:0] S_MID  = SW'(OVS / 2 - 1);
  localparam logic [SW-1:0] S_BIT  = SW'(OVS - 1);
  localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t          state_q, state_d;
  logic            sync_q, rx_s_q;
  logic [SW-1:0]   s_q, s_d;
  logic [NW-1:0]   n_q, n_d;
  logic [DBIT-1:0] shift_q, shift_d;
  logic            p_q, p_d;
  logic            pen_q, pen_d;
  logic            podd_q, podd_d;
  logic [DBIT-1:0] dout_q, dout_d;
  logic            done_q, done_d;
  logic            perr_q, perr_d;
  logic            ferr_q, ferr_d;
  logic            brk_q, brk_d;
  logic            perr_w;

  // Mismatch between received parity bit and the mode latched at frame start.
  assign perr_w = pen_q & ((^shift_q) ^ p_q ^ podd_q);

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    shift_d = shift_q;
    p_d     = p_q;
    pen_d   = pen_q;
    podd_d  = podd_q;
    dout_d  = dout_q;
    done_d  = 1'b0;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    brk_d   = brk_q;
    case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          state_d = START;
          s_d     = '0;
          pen_d   = bus.par_en;
          podd_d  = bus.par_odd;
        end
      end
      START: begin
        if (bus.s_tick) begin
          if (s_q == S_MID) begin
            // A line that is high again at mid start bit was only a glitch.
            if (!rx_s_q) begin
              state_d = DATA;
              s_d     = '0;
              n_d     = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      DATA: begin
        if (bus.s_tick) begin
          if (s_q == S_BIT) begin
            s_d     = '0;
            shift_d = {rx_s_q, shift_q[DBIT-1:1]};
            if (n_q == N_LAST) begin
              state_d = pen_q ? PARITY : STOP;
            end else begin
              n_d = n_q + NW'(1);
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      PARITY: begin
        if (bus.s_tick) begin
          if (s_q == S_BIT) begin
            p_d     = rx_s_q;
            s_d     = '0;
            state_d = STOP;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      STOP: begin
        if (bus.s_tick) begin
          if (s_q == S_STOP) begin
            state_d = IDLE;
            dout_d  = shift_q;
            perr_d  = perr_w;
            ferr_d  = ~rx_s_q;
            brk_d   = ~rx_s_q & (shift_q == '0) & (~pen_q | ~p_q);
            done_d  = 1'b1;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sync_q  <= 1'b1;
      rx_s_q  <= 1'b1;
      s_q     <= '0;
      n_q     <= '0;
      shift_q <= '0;
      p_q     <= 1'b0;
      pen_q   <= 1'b0;
      podd_q  <= 1'b0;
      dout_q  <= '0;
      done_q  <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      brk_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= bus.rx;
      rx_s_q  <= sync_q;
      s_q     <= s_d;
      n_q     <= n_d;
      shift_q <= shift_d;
      p_q     <= p_d;
      pen_q   <= pen_d;
      podd_q  <= podd_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      brk_q   <= brk_d;
    end
  end

  assign bus.rx_dout      = dout_q;
  assign bus.rx_done_tick = done_q;
  assign bus.parity_err   = perr_q;
  assign bus.frame_err    = ferr_q;
  assign bus.break_det    = brk_q;
endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: two configurations (8N/OVS16 and 7-bit/OVS8/2 stop)
// driven with directed and random frames, checked against a frame-level model.
module tb_uart_rx_cfg;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic s_tick = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   done0 = 0;
  int   done1 = 0;

  typedef struct packed {
    logic [8:0] dout;
    logic       perr;
    logic       ferr;
    logic       brk;
  } rec_t;

  rec_t q0[$];
  rec_t q1[$];

  uart_rx_cfg_if #(.DBIT(8)) if0 ();
  uart_rx_cfg_if #(.DBIT(7)) if1 ();

  uart_rx_cfg #(.DBIT(8), .OVS(16), .SB_TICK(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0.master)
  );
  uart_rx_cfg #(.DBIT(7), .OVS(8), .SB_TICK(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1.master)
  );

  initial forever #5 clk = ~clk;

  // One-clk s_tick every 4 clocks, shared by both receivers.
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clk);
      cnt = (cnt + 1) % 4;
      s_tick = (cnt == 0);
      if0.s_tick = s_tick;
      if1.s_tick = s_tick;
    end
  end

  // Capture every completed frame, one entry per clk the done pulse is high.
  initial forever begin
    rec_t r;
    @(negedge clk);
    if (if0.rx_done_tick === 1'b1) begin
      r.dout = {1'b0, if0.rx_dout};
      r.perr = if0.parity_err;
      r.ferr = if0.frame_err;
      r.brk  = if0.break_det;
      q0.push_back(r);
      done0++;
    end
    if (if1.rx_done_tick === 1'b1) begin
      r.dout = {2'b00, if1.rx_dout};
      r.perr = if1.parity_err;
      r.ferr = if1.frame_err;
      r.brk  = if1.break_det;
      q1.push_back(r);
      done1++;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic rec_t model(input logic [8:0] data, input int dbit, input bit pen,
                                 input bit podd, input bit p, input bit stop);
    rec_t r;
    logic [8:0] d;
    int ones;
    d = data & 9'((1 << dbit) - 1);
    ones = $countones(d);
    r.dout = d;
    r.perr = pen && (((ones + int'(p) + int'(podd)) % 2) == 1);
    r.ferr = !stop;
    r.brk  = !stop && (d == 9'd0) && (!pen || !p);
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      while (s_tick !== 1'b1) @(posedge clk);
    end
  endtask

  task automatic drive(input bit sel, input logic v);
    @(negedge clk);
    if (sel) if1.rx = v;
    else     if0.rx = v;
  endtask

  // Line waveform of one frame; a low stop bit lasts just past the sample point.
  task automatic send_frame(input bit sel, input logic [8:0] data, input bit pen,
                            input bit p, input bit stop);
    int ovs, dbit;
    ovs  = sel ? 8 : 16;
    dbit = sel ? 7 : 8;
    drive(sel, 1'b0);
    wait_ticks(ovs);
    for (int i = 0; i < dbit; i++) begin
      drive(sel, data[i]);
      wait_ticks(ovs);
    end
    if (pen) begin
      drive(sel, p);
      wait_ticks(ovs);
    end
    if (stop) begin
      drive(sel, 1'b1);
      wait_ticks(16);
    end else begin
      drive(sel, 1'b0);
      wait_ticks(16 - ovs / 2 + 2);
      drive(sel, 1'b1);
      wait_ticks(ovs / 2);
    end
  endtask

  task automatic expect_frame(input bit sel, input string tag, input rec_t exp);
    rec_t got;
    int budget;
    budget = 4000;
    while (((sel ? q1.size() : q0.size()) == 0) && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check({tag, ".done"}, 32'((sel ? q1.size() : q0.size()) != 0), 32'd1);
    if ((sel ? q1.size() : q0.size()) == 0) return;
    got = sel ? q1.pop_front() : q0.pop_front();
    $display("frame %s dout=%0h perr=%0b ferr=%0b brk=%0b", tag, got.dout, got.perr, got.ferr, got.brk);
    check({tag, ".dout"}, 32'(got.dout), 32'(exp.dout));
    check({tag, ".perr"}, 32'(got.perr), 32'(exp.perr));
    check({tag, ".ferr"}, 32'(got.ferr), 32'(exp.ferr));
    check({tag, ".brk"},  32'(got.brk),  32'(exp.brk));
  endtask

  initial begin
    rec_t last;
    int   n0, n1;
    bit   sel, pen, podd, p, stop;
    logic [8:0] data;
    logic [7:0] f0;

    if0.rx = 1'b1;  if1.rx = 1'b1;
    if0.par_en = 1'b0; if0.par_odd = 1'b0;
    if1.par_en = 1'b0; if1.par_odd = 1'b0;
    if0.s_tick = 1'b0; if1.s_tick = 1'b0;
    rst_n = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("rst.dout", 32'(if0.rx_dout), 32'd0);
    check("rst.done", 32'(if0.rx_done_tick), 32'd0);
    check("rst.perr", 32'(if0.parity_err), 32'd0);
    check("rst.ferr", 32'(if0.frame_err), 32'd0);
    check("rst.brk",  32'(if0.break_det), 32'd0);
    check("rst.dout1", 32'(if1.rx_dout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_ticks(20);

    // Plain 8N1 frame
    n0 = done0;
    send_frame(1'b0, 9'h55, 1'b0, 1'b0, 1'b1);
    expect_frame(1'b0, "t1_55", model(9'h55, 8, 0, 0, 0, 1));
    wait_ticks(16);
    check("t1.pulses", 32'(done0 - n0), 32'd1);

    // Even then odd parity
    if0.par_en = 1'b1; if0.par_odd = 1'b0;
    send_frame(1'b0, 9'hA3, 1'b1, 1'b0, 1'b1);
    expect_frame(1'b0, "t2_even_p0", model(9'hA3, 8, 1, 0, 0, 1));
    wait_ticks(16);
    send_frame(1'b0, 9'hA3, 1'b1, 1'b1, 1'b1);
    expect_frame(1'b0, "t2_even_p1", model(9'hA3, 8, 1, 0, 1, 1));
    wait_ticks(16);
    if0.par_odd = 1'b1;
    send_frame(1'b0, 9'hA3, 1'b1, 1'b1, 1'b1);
    last = model(9'hA3, 8, 1, 1, 1, 1);
    expect_frame(1'b0, "t2_odd_p1", last);
    wait_ticks(16);

    // Short low pulse is rejected as a start glitch
    if0.par_en = 1'b0; if0.par_odd = 1'b0;
    n0 = done0;
    drive(1'b0, 1'b0);
    wait_ticks(4);
    drive(1'b0, 1'b1);
    wait_ticks(40);
    check("t3.no_done", 32'(done0 - n0), 32'd0);
    check("t3.dout_hold", 32'(if0.rx_dout), 32'(last.dout));
    check("t3.perr_hold", 32'(if0.parity_err), 32'(last.perr));
    send_frame(1'b0, 9'h3C, 1'b0, 1'b0, 1'b1);
    expect_frame(1'b0, "t3_3c", model(9'h3C, 8, 0, 0, 0, 1));
    wait_ticks(16);

    // Framing error, then a held break
    send_frame(1'b0, 9'h81, 1'b0, 1'b0, 1'b0);
    expect_frame(1'b0, "t4_81_ferr", model(9'h81, 8, 0, 0, 0, 0));
    wait_ticks(16);
    drive(1'b0, 1'b0);
    expect_frame(1'b0, "t4_brk1", model(9'h000, 8, 0, 0, 0, 0));
    expect_frame(1'b0, "t4_brk2", model(9'h000, 8, 0, 0, 0, 0));
    drive(1'b0, 1'b1);
    n0 = done0;
    wait_ticks(48);
    check("t4.no_spurious", 32'(done0 - n0), 32'd0);

    // Reset in the middle of the data bits
    n0 = done0;
    f0 = 8'hF0;
    drive(1'b0, 1'b0);
    wait_ticks(16);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, f0[i]);
      wait_ticks(16);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t5.dout", 32'(if0.rx_dout), 32'd0);
    check("t5.ferr", 32'(if0.frame_err), 32'd0);
    check("t5.brk",  32'(if0.break_det), 32'd0);
    check("t5.done", 32'(if0.rx_done_tick), 32'd0);
    if0.rx = 1'b1;
    repeat (8) @(negedge clk);
    rst_n = 1'b1;
    wait_ticks(40);
    check("t5.no_done", 32'(done0 - n0), 32'd0);
    send_frame(1'b0, 9'h0F, 1'b0, 1'b0, 1'b1);
    expect_frame(1'b0, "t5_0f", model(9'h0F, 8, 0, 0, 0, 1));
    wait_ticks(16);

    // 7-bit, odd parity, two stop bits, back to back
    if1.par_en = 1'b1; if1.par_odd = 1'b1;
    n1 = done1;
    send_frame(1'b1, 9'h7F, 1'b1, 1'b0, 1'b1);
    send_frame(1'b1, 9'h00, 1'b1, 1'b1, 1'b1);
    expect_frame(1'b1, "t6_7f", model(9'h7F, 7, 1, 1, 0, 1));
    expect_frame(1'b1, "t6_00", model(9'h00, 7, 1, 1, 1, 1));
    check("t6.pulses", 32'(done1 - n1), 32'd2);
    wait_ticks(16);

    // Mode ports change mid-frame; the frame keeps its latched mode
    fork
      send_frame(1'b1, 9'h2A, 1'b1, 1'b0, 1'b1);
      begin
        wait_ticks(30);
        if1.par_en = 1'b0;
        if1.par_odd = 1'b0;
      end
    join
    expect_frame(1'b1, "t6_2a_latched", model(9'h2A, 7, 1, 1, 0, 1));
    wait_ticks(8);
    send_frame(1'b1, 9'h15, 1'b0, 1'b0, 1'b1);
    expect_frame(1'b1, "t6_15_nopar", model(9'h15, 7, 0, 0, 0, 1));
    wait_ticks(8);

    // Random frames on either receiver
    for (int k = 0; k < 24; k++) begin
      sel  = 1'($urandom % 2);
      data = 9'($urandom);
      pen  = 1'($urandom % 2);
      podd = 1'($urandom % 2);
      p    = 1'($urandom % 2);
      stop = (($urandom % 6) != 0);
      if (sel) begin
        if1.par_en = pen; if1.par_odd = podd;
      end else begin
        if0.par_en = pen; if0.par_odd = podd;
      end
      send_frame(sel, data, pen, p, stop);
      expect_frame(sel, $sformatf("rnd%0d", k), model(data, sel ? 7 : 8, pen, podd, p, stop));
      wait_ticks(16);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
